// File: rtl/decode_pipe_pkg.sv
// Shared decode definitions: control-vector bit map, opcode/funct encodings,
// stage FSM encoding and small helpers used by the decode pipeline.
package decode_pipe_pkg;

  // Minimum control-vector width; wider vectors carry zeros above this.
  localparam int CNTRL_W_MIN = 9;

  // Control-vector bit positions.
  localparam int BR_B     = 0;
  localparam int JP_B     = 1;
  localparam int JR_B     = 2;
  localparam int ALUINB_B = 3;
  localparam int ALUOP_B  = 4;
  localparam int DMWE_B   = 5;
  localparam int RWE_B    = 6;
  localparam int RDST_B   = 7;
  localparam int RWD_B    = 8;

  typedef logic [CNTRL_W_MIN-1:0] ctrl_base_t;

  localparam ctrl_base_t M_BR     = ctrl_base_t'(1) << BR_B;
  localparam ctrl_base_t M_JP     = ctrl_base_t'(1) << JP_B;
  localparam ctrl_base_t M_JR     = ctrl_base_t'(1) << JR_B;
  localparam ctrl_base_t M_ALUINB = ctrl_base_t'(1) << ALUINB_B;
  localparam ctrl_base_t M_ALUOP  = ctrl_base_t'(1) << ALUOP_B;
  localparam ctrl_base_t M_DMWE   = ctrl_base_t'(1) << DMWE_B;
  localparam ctrl_base_t M_RWE    = ctrl_base_t'(1) << RWE_B;
  localparam ctrl_base_t M_RDST   = ctrl_base_t'(1) << RDST_B;
  localparam ctrl_base_t M_RWD    = ctrl_base_t'(1) << RWD_B;

  // Primary opcodes (insn[31:26]).
  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SW       = 6'h2B;

  // SPECIAL function codes (insn[5:0]).
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam logic [5:0] F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // SPECIAL2 function code for MUL.
  localparam logic [5:0] F2_MUL = 6'h02;

  // Output-slot occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_BUBBLE = 2'd2
  } state_t;

  // Sign-extend a 16-bit immediate field.
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/decode_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_pipe_if
  import decode_pipe_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int CNTRL_W = CNTRL_W_MIN
);
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        insn;
  logic [PC_W-1:0]    pc;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic [4:0]         rd;
  logic [31:0]        imm;
  logic [CNTRL_W-1:0] control;
  logic               illegal;
  logic               bubble;

  // Fetch/execute environment side.
  modport master (
    output in_valid, insn, pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, rs, rt, rd, imm, control, illegal, bubble
  );

  // Decode stage side.
  modport slave (
    input  in_valid, insn, pc, flush, out_ready,
    output in_ready, out_valid, out_pc, rs, rt, rd, imm, control, illegal, bubble
  );
endinterface

// File: rtl/decode_pipe_decode_table.sv
// Combinational instruction decoder: opcode/funct table to control vector,
// illegal flag and extended immediate.
module decode_table
  import decode_pipe_pkg::*;
#(
  parameter int CNTRL_W = CNTRL_W_MIN
) (
  input  logic [31:0]        insn,
  output logic [CNTRL_W-1:0] control,
  output logic               illegal,
  output logic [31:0]        imm
);

  logic [5:0] opcode;
  logic [5:0] funct;
  ctrl_base_t base;

  assign opcode = insn[31:26];
  assign funct  = insn[5:0];

  // Table lookup; an untabled encoding flags illegal and leaves control zero.
  always_comb begin
    base    = '0;
    illegal = 1'b0;
    if (insn != 32'h0000_0000) begin
      case (opcode)
        OP_SPECIAL: begin
          case (funct)
            F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
            F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
            F_MFHI, F_MFLO:
              base = M_RWE | M_RDST;
            F_DIV, F_DIVU:
              base = M_RWE;
            F_JR:
              base = M_JP | M_JR;
            F_JALR:
              base = M_JP | M_JR | M_RWE | M_RDST;
            default:
              illegal = 1'b1;
          endcase
        end
        OP_SPECIAL2: begin
          if (funct == F2_MUL) base = M_RWE | M_RDST;
          else                 illegal = 1'b1;
        end
        OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ORI, OP_XORI, OP_LUI:
          base = M_ALUINB | M_RWE;
        OP_LW, OP_LB, OP_LBU:
          base = M_ALUINB | M_RWE | M_RWD;
        OP_SW, OP_SB:
          base = M_ALUINB | M_DMWE;
        OP_J:
          base = M_JP;
        OP_JAL:
          base = M_JP | M_RWE;
        OP_BEQ, OP_BNE, OP_REGIMM, OP_BLEZ, OP_BGTZ:
          base = M_BR | M_ALUOP;
        default:
          illegal = 1'b1;
      endcase
    end
  end

  // Widen the base vector; bits above the defined set stay zero.
  always_comb begin
    control                      = '0;
    control[CNTRL_W_MIN-1:0]     = base;
  end

  // Immediate extension: logical ops zero-extend, LUI shifts up, rest sign-extend.
  always_comb begin
    case (opcode)
      OP_ORI, OP_XORI: imm = {16'h0000, insn[15:0]};
      OP_LUI:          imm = {insn[15:0], 16'h0000};
      default:         imm = sext16(insn[15:0]);
    endcase
  end

endmodule

// File: rtl/decode_pipe.sv
// Single-slot registered decode stage with fetch/execute valid-ready
// handshakes, load-use bubble insertion and flush.
module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int CNTRL_W   = CNTRL_W_MIN,
  parameter int HAZARD_EN = 1
) (
  input logic          clk,
  input logic          rst_n,
  decode_pipe_if.slave bus
);

  state_t             state_q;
  state_t             state_d;

  logic [CNTRL_W-1:0] ctrl_p0;
  logic               illegal_p0;
  logic [31:0]        imm_p0;
  logic [4:0]         rs_p0;
  logic [4:0]         rt_p0;
  logic [4:0]         rd_p0;

  logic [PC_W-1:0]    pc_p1;
  logic [4:0]         rs_p1;
  logic [4:0]         rt_p1;
  logic [4:0]         rd_p1;
  logic [31:0]        imm_p1;
  logic [CNTRL_W-1:0] ctrl_p1;
  logic               illegal_p1;
  logic               bubble_p1;
  logic               vld_p1;

  logic               hazard;
  logic               in_ready;
  logic               accept;
  logic               load_bubble;

  // ---- stage p0: combinational decode of the incoming instruction ----
  assign rs_p0 = bus.insn[25:21];
  assign rt_p0 = bus.insn[20:16];
  assign rd_p0 = bus.insn[15:11];

  decode_table #(.CNTRL_W(CNTRL_W)) u_decode_table (
    .insn    (bus.insn),
    .control (ctrl_p0),
    .illegal (illegal_p0),
    .imm     (imm_p0)
  );

  assign vld_p1 = (state_q != ST_EMPTY);

  // Load-use check: held load writes rt, incoming instruction reads it.
  always_comb begin
    hazard = 1'b0;
    if ((HAZARD_EN != 0) && (state_q == ST_FULL) &&
        ctrl_p1[RWD_B] && ctrl_p1[RWE_B] && (rt_p1 != 5'd0) &&
        bus.in_valid && !bus.flush &&
        ((rs_p0 == rt_p1) || (rt_p0 == rt_p1)))
      hazard = 1'b1;
  end

  // Handshake decisions and next slot state; flush overrides everything.
  always_comb begin
    in_ready    = (!vld_p1 || bus.out_ready) && !hazard && !bus.flush;
    accept      = bus.in_valid && in_ready;
    load_bubble = hazard && bus.out_ready;
    state_d     = state_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) state_d = ST_FULL;
        end
        ST_FULL: begin
          if (bus.out_ready) begin
            if (hazard)      state_d = ST_BUBBLE;
            else if (accept) state_d = ST_FULL;
            else             state_d = ST_EMPTY;
          end
        end
        ST_BUBBLE: begin
          if (bus.out_ready) state_d = accept ? ST_FULL : ST_EMPTY;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // ---- stage p1: registered outputs, loaded on accept or bubble insert ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p1      <= '0;
      rs_p1      <= '0;
      rt_p1      <= '0;
      rd_p1      <= '0;
      imm_p1     <= '0;
      ctrl_p1    <= '0;
      illegal_p1 <= 1'b0;
      bubble_p1  <= 1'b0;
    end else if (accept) begin
      pc_p1      <= bus.pc;
      rs_p1      <= rs_p0;
      rt_p1      <= rt_p0;
      rd_p1      <= rd_p0;
      imm_p1     <= imm_p0;
      ctrl_p1    <= ctrl_p0;
      illegal_p1 <= illegal_p0;
      bubble_p1  <= 1'b0;
    end else if (load_bubble) begin
      pc_p1      <= '0;
      rs_p1      <= '0;
      rt_p1      <= '0;
      rd_p1      <= '0;
      imm_p1     <= '0;
      ctrl_p1    <= '0;
      illegal_p1 <= 1'b0;
      bubble_p1  <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p1;
  assign bus.out_pc    = pc_p1;
  assign bus.rs        = rs_p1;
  assign bus.rt        = rt_p1;
  assign bus.rd        = rd_p1;
  assign bus.imm       = imm_p1;
  assign bus.control   = ctrl_p1;
  assign bus.illegal   = illegal_p1;
  assign bus.bubble    = bubble_p1;

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: directed instructions with hand-decoded
// expectations queued at issue, checked by per-DUT output monitors.
// Control bit map: BR=0 JP=1 JR=2 ALUINB=3 ALUOP=4 DMWE=5 RWE=6 RDST=7 RWD=8.
module tb_decode_pipe;

  logic clk;
  logic rst_n;

  decode_pipe_if #(.PC_W(32), .CNTRL_W(9)) bus_a ();
  decode_pipe_if #(.PC_W(32), .CNTRL_W(9)) bus_b ();

  decode_pipe #(.PC_W(32), .CNTRL_W(9), .HAZARD_EN(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  decode_pipe #(.PC_W(32), .CNTRL_W(9), .HAZARD_EN(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [8:0]  ctrl;
    logic        ill;
    logic        bub;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_pass  = 0;
  int n_total = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [31:0] imm, input logic [8:0] ctrl,
                              input logic ill, input logic bub);
    exp_t e;
    e.pc = pc; e.rs = rs; e.rt = rt; e.rd = rd;
    e.imm = imm; e.ctrl = ctrl; e.ill = ill; e.bub = bub;
    return e;
  endfunction

  task automatic compare_beat(input string tag, input exp_t e, input logic [31:0] pc,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] imm, input logic [8:0] ctrl,
                              input logic ill, input logic bub);
    check({tag, "_control"}, ctrl, e.ctrl);
    check({tag, "_illegal"}, ill, e.ill);
    check({tag, "_bubble"}, bub, e.bub);
    if (!e.bub) begin
      check({tag, "_pc"}, pc, e.pc);
      check({tag, "_rs"}, rs, e.rs);
      check({tag, "_rt"}, rt, e.rt);
      check({tag, "_rd"}, rd, e.rd);
      check({tag, "_imm"}, imm, e.imm);
    end
  endtask

  // Monitor for the hazard-enabled DUT: one beat per valid&ready cycle.
  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_beat", {32'h0, bus_a.out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = q_a.pop_front();
          compare_beat("a", e, bus_a.out_pc, bus_a.rs, bus_a.rt, bus_a.rd,
                       bus_a.imm, bus_a.control, bus_a.illegal, bus_a.bubble);
        end
      end
    end
  end

  // Monitor for the hazard-disabled DUT.
  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus_b.out_valid && bus_b.out_ready) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_beat", {32'h0, bus_b.out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = q_b.pop_front();
          compare_beat("b", e, bus_b.out_pc, bus_b.rs, bus_b.rt, bus_b.rd,
                       bus_b.imm, bus_b.control, bus_b.illegal, bus_b.bubble);
        end
      end
    end
  end

  task automatic send_a(input logic [31:0] i, input logic [31:0] p, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    bus_a.in_valid = 1'b1;
    bus_a.insn     = i;
    bus_a.pc       = p;
    while (!done) begin
      @(negedge clk);
      if (bus_a.in_ready) begin
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 50) begin
          check("a_send_timeout", waits, 0);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] i, input logic [31:0] p, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    bus_b.in_valid = 1'b1;
    bus_b.insn     = i;
    bus_b.pc       = p;
    while (!done) begin
      @(negedge clk);
      if (bus_b.in_ready) begin
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 50) begin
          check("b_send_timeout", waits, 0);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, q_a.size() + q_b.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int w;
    rst_n = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.insn = '0; bus_a.pc = '0; bus_a.flush = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.insn = '0; bus_b.pc = '0; bus_b.flush = 1'b0; bus_b.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_control", bus_a.control, 0);
    check("rst_imm", bus_a.imm, 0);
    check("rst_out_pc", bus_a.out_pc, 0);
    check("rst_regs", {bus_a.rs, bus_a.rt, bus_a.rd}, 0);
    check("rst_flags", {bus_a.illegal, bus_a.bubble}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode table stream, back-to-back with out_ready=1
    q_a.push_back(mk(32'h100, 5'd2, 5'd2, 5'd31, 32'h0000_FFFF, 9'h048, 1'b0, 1'b0)); // ORI
    send_a(32'h3442_FFFF, 32'h100, w);
    q_a.push_back(mk(32'h104, 5'd0, 5'd2, 5'd2, 32'h1234_0000, 9'h048, 1'b0, 1'b0));  // LUI
    send_a(32'h3C02_1234, 32'h104, w);
    q_a.push_back(mk(32'h108, 5'd0, 5'd0, 5'd0, 32'h0, 9'h000, 1'b1, 1'b0));          // opcode 0x3F
    send_a(32'hFC00_0000, 32'h108, w);
    q_a.push_back(mk(32'h10C, 5'd0, 5'd0, 5'd0, 32'h0, 9'h000, 1'b0, 1'b0));          // noop
    send_a(32'h0000_0000, 32'h10C, w);
    q_a.push_back(mk(32'h110, 5'd2, 5'd3, 5'd0, 32'h4, 9'h028, 1'b0, 1'b0));          // SW
    send_a(32'hAC43_0004, 32'h110, w);
    q_a.push_back(mk(32'h114, 5'd2, 5'd3, 5'd31, 32'hFFFF_FFFE, 9'h011, 1'b0, 1'b0)); // BEQ
    send_a(32'h1043_FFFE, 32'h114, w);
    q_a.push_back(mk(32'h118, 5'd31, 5'd0, 5'd0, 32'h8, 9'h006, 1'b0, 1'b0));         // JR
    send_a(32'h03E0_0008, 32'h118, w);
    q_a.push_back(mk(32'h11C, 5'd0, 5'd0, 5'd0, 32'h1, 9'h000, 1'b1, 1'b0));          // bad funct
    send_a(32'h0000_0001, 32'h11C, w);
    drain("drain_table");

    // Backpressure: ADDIU held for three cycles
    bus_a.out_ready = 1'b0;
    q_a.push_back(mk(32'h200, 5'd1, 5'd2, 5'd0, 32'h5, 9'h048, 1'b0, 1'b0));
    send_a(32'h2422_0005, 32'h200, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_out_valid", bus_a.out_valid, 1);
      check("bp_in_ready", bus_a.in_ready, 0);
      check("bp_imm", bus_a.imm, 32'h5);
      check("bp_control", bus_a.control, 9'h048);
      check("bp_out_pc", bus_a.out_pc, 32'h200);
    end
    @(posedge clk); #1;
    bus_a.out_ready = 1'b1;
    drain("drain_bp");

    // Load-use with hazard detection: LW, bubble, ADDU
    q_a.push_back(mk(32'h300, 5'd2, 5'd3, 5'd0, 32'h0, 9'h148, 1'b0, 1'b0));
    q_a.push_back(mk(32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 9'h000, 1'b0, 1'b1));
    q_a.push_back(mk(32'h304, 5'd3, 5'd2, 5'd2, 32'h0000_1021, 9'h0C0, 1'b0, 1'b0));
    send_a(32'h8C43_0000, 32'h300, w);
    send_a(32'h0062_1021, 32'h304, w);
    check("loaduse_stall_cycles", w, 1);
    drain("drain_loaduse");

    // Same stream with hazard detection disabled: no bubble, no stall
    q_b.push_back(mk(32'h300, 5'd2, 5'd3, 5'd0, 32'h0, 9'h148, 1'b0, 1'b0));
    q_b.push_back(mk(32'h304, 5'd3, 5'd2, 5'd2, 32'h0000_1021, 9'h0C0, 1'b0, 1'b0));
    send_b(32'h8C43_0000, 32'h300, w);
    send_b(32'h0062_1021, 32'h304, w);
    check("nohaz_stall_cycles", w, 0);
    drain("drain_nohaz");

    // Flush while FULL with an incoming instruction
    bus_a.out_ready = 1'b0;
    send_a(32'h2422_0005, 32'h400, w);
    bus_a.in_valid = 1'b1;
    bus_a.insn     = 32'h3442_FFFF;
    bus_a.pc       = 32'h404;
    bus_a.flush    = 1'b1;
    @(negedge clk);
    check("flush_in_ready", bus_a.in_ready, 0);
    @(posedge clk); #1;
    bus_a.flush     = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", bus_a.out_valid, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-stream while FULL
    bus_a.out_ready = 1'b0;
    send_a(32'h2422_0005, 32'h500, w);
    bus_a.in_valid = 1'b1;
    bus_a.insn     = 32'h3C02_1234;
    bus_a.pc       = 32'h504;
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", bus_a.out_valid, 0);
    check("rstmid_control", bus_a.control, 0);
    @(posedge clk); #1;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstmid_idle_out_valid", bus_a.out_valid, 0);
    end
    @(posedge clk); #1;
    q_a.push_back(mk(32'h600, 5'd0, 5'd2, 5'd2, 32'h1234_0000, 9'h048, 1'b0, 1'b0));
    send_a(32'h3C02_1234, 32'h600, w);
    drain("drain_after_reset");

    repeat (3) @(posedge clk);
    check("final_queues_empty", q_a.size() + q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning program-counter width.
REQ-002 SHALL have parameter CNTRL_W, default 9, meaning control-vector width, at least 9.
REQ-003 SHALL have parameter HAZARD_EN, default 1, meaning load-use bubble insertion enabled.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): fetch handshake.
REQ-007 SHALL have ports insn (input, 32) and pc (input, PC_W): fetched instruction and its address.
REQ-008 SHALL have port flush, input, 1: discard held and incoming instruction.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): execute-side handshake.
REQ-010 SHALL have ports out_pc (output, PC_W) and rs, rt, rd (outputs, 5 each): insn[25:21], insn[20:16], insn[15:11].
REQ-011 SHALL have port imm, output, 32: extended immediate.
REQ-012 SHALL have port control, output, CNTRL_W: bits BR, JP, JR, ALUINB, ALUOP, DMWE, RWE, RDST, RWD; upper bits zero.
REQ-013 SHALL have ports illegal (output, 1: opcode/funct not in table) and bubble (output, 1: slot is an inserted noop).

Function
REQ-014 SHALL register all outputs: one-cycle latency from accept (in_valid & in_ready) to out_valid.
REQ-015 SHALL implement states EMPTY, FULL, BUBBLE; EMPTY->FULL on accept; FULL->EMPTY on out_ready without accept; FULL->FULL on out_ready with accept; FULL->BUBBLE on hazard; BUBBLE->FULL on out_ready with accept, else BUBBLE->EMPTY on out_ready.
REQ-016 SHALL drive in_ready = (!out_valid | out_ready) & !hazard & !flush.
REQ-017 SHALL hold all outputs stable while out_valid & !out_ready.
REQ-018 SHALL detect hazard when HAZARD_EN, state FULL, held control has RWD=1 and RWE=1, held rt is nonzero, in_valid=1, and insn rs or rt equals held rt.
REQ-019 SHALL, on hazard with out_ready, load a bubble: out_valid=1, control=0, bubble=1, illegal=0, insn not consumed.
REQ-020 SHALL decode SPECIAL funct ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SRL/SRA/SLLV/SRLV/SRAV and MUL (opcode 011100) as RWE=1, RDST=1.
REQ-021 SHALL decode DIV/DIVU as RWE=1; MFHI/MFLO as RWE=1, RDST=1; JR as JP=1, JR=1; JALR as JP=1, JR=1, RWE=1, RDST=1.
REQ-022 SHALL decode ADDIU/SLTI/SLTIU/ORI/XORI/LUI as ALUINB=1, RWE=1; LW/LB/LBU as ALUINB=1, RWE=1, RWD=1; SW/SB as ALUINB=1, DMWE=1.
REQ-023 SHALL decode J as JP=1; JAL as JP=1, RWE=1; BEQ/BNE/REGIMM/BLEZ/BGTZ as BR=1, ALUOP=1.
REQ-024 SHALL extend imm: zero-extend for ORI/XORI, {insn[15:0],16'h0} for LUI, sign-extend otherwise.
REQ-025 SHALL treat insn 32'h00000000 as noop: control=0, illegal=0, bubble=0, out_valid=1.
REQ-026 SHALL, for an untabled opcode/funct, set illegal=1 and control=0.
REQ-027 SHALL give flush priority: next state EMPTY, out_valid=0, no accept, hazard tracking cleared.

Reset
REQ-028 SHALL, while rst_n=0, force state EMPTY, out_valid=0, control=0, imm=0, out_pc=0, rs=rt=rd=0, illegal=0, bubble=0.
REQ-029 SHALL drop any in-flight instruction on reset mid-operation and accept none until first edge after rst_n rises.

Structure
REQ-030 SHALL take control bit indices, CNTRL_W minimum, opcode and funct constants from shared header control.vh.
REQ-031 SHALL place the combinational opcode/funct table in sub-module decode_table (insn -> control, illegal, imm).

Verification
REQ-032 Reset mid-stream: rst_n=0 while FULL -> out_valid=0, control=0 immediately; no output after release until new accept.
REQ-033 Backpressure: ADDIU 0x24220005 accepted, out_ready=0 three cycles -> outputs stable, in_ready=0, imm=0x00000005.
REQ-034 Load-use: LW 0x8C430000 then ADDU 0x00621021 back-to-back, out_ready=1 -> LW, bubble (control=0, bubble=1), ADDU; in_ready=0 one cycle.
REQ-035 HAZARD_EN=0, same stream -> LW, ADDU in consecutive cycles, no bubble.
REQ-036 Flush with in_valid=1 while FULL -> out_valid=0 next cycle, incoming insn not consumed.
REQ-037 Immediates/illegal: ORI 0x3442FFFF -> imm 0x0000FFFF; LUI 0x3C021234 -> imm 0x12340000; opcode 0x3F -> illegal=1, control=0.
